tlc_lamp_monitor: RTL and testbench

- Receive-side checker for the two-road traffic-light controller lamp outputs.
- Samples lamp_a/lamp_b (RED=00, YEL=01, GRN=10) every clk and decodes the current phase.
- Verifies phase order and phase durations, reconstructs the per-phase countdown and counts complete light cycles.
- Sits beside the controller as a safety watchdog; its sticky fault flags feed the system alarm logic.

---
 rtl/tlc_lamp_monitor.sv | 193 +++++++++++++++++++
 tb/tb_tlc_lamp_monitor.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tlc_lamp_monitor.sv
// Lamp-pattern watchdog for the two-road light controller: tracks phase order/durations, counts cycles, latches faults.
// Outputs registered, one cycle after the lamp sample; TLC_MON_STRICT_START_EN starts locked in AG straight out of reset.
module tlc_lamp_monitor #(
  parameter int T_AG  = 5,
  parameter int T_AY  = 2,
  parameter int T_BG  = 5,
  parameter int T_BY  = 2,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       lamp_a,
  input  logic [1:0]       lamp_b,
  input  logic             clr_fault,
  output logic             locked,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] countdown,
  output logic [7:0]       cycles,
  output logic             fault_pulse,
  output logic [3:0]       fault_flags
);

  localparam logic [1:0] LAMP_RED = 2'b00;
  localparam logic [1:0] LAMP_YEL = 2'b01;
  localparam logic [1:0] LAMP_GRN = 2'b10;

  localparam logic [1:0] PH_AG = 2'd0;
  localparam logic [1:0] PH_AY = 2'd1;
  localparam logic [1:0] PH_BG = 2'd2;
  localparam logic [1:0] PH_BY = 2'd3;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    ST_SYNC,
    ST_TRACK
  } state_t;

  function automatic logic [CNT_W-1:0] t_of(input logic [1:0] p);
    case (p)
      PH_AG:   t_of = CNT_W'(T_AG);
      PH_AY:   t_of = CNT_W'(T_AY);
      PH_BG:   t_of = CNT_W'(T_BG);
      default: t_of = CNT_W'(T_BY);
    endcase
  endfunction

  state_t           state_q, state_nx;
  logic [1:0]       phase_q, phase_nx;
  logic [CNT_W-1:0] cnt_q, cnt_nx;
  logic             held_vld_q, held_vld_nx;
  logic [1:0]       held_phase_q, held_phase_nx;
  logic [7:0]       cycles_q, cycles_nx;
  logic [CNT_W-1:0] countdown_q, countdown_nx;
  logic             pulse_q;
  logic [3:0]       flags_q, flags_nx;

  logic             samp_legal;
  logic [1:0]       samp_phase;
  logic             samp_conflict;
  logic             samp_illegal;
  logic             f_seq, f_timing;
  logic             any_fault;
  logic [CNT_W-1:0] t_cur;
  logic             start_pending;

  // Pattern decode: only the four legal pairs map to a phase
  always_comb begin
    samp_legal = 1'b1;
    samp_phase = PH_AG;
    case ({lamp_a, lamp_b})
      {LAMP_GRN, LAMP_RED}: samp_phase = PH_AG;
      {LAMP_YEL, LAMP_RED}: samp_phase = PH_AY;
      {LAMP_RED, LAMP_GRN}: samp_phase = PH_BG;
      {LAMP_RED, LAMP_YEL}: samp_phase = PH_BY;
      default:              samp_legal = 1'b0;
    endcase
  end

  assign samp_conflict = (lamp_a == LAMP_YEL || lamp_a == LAMP_GRN) &&
                         (lamp_b == LAMP_YEL || lamp_b == LAMP_GRN);
  assign samp_illegal  = !samp_legal && !samp_conflict;
  assign t_cur         = t_of(phase_q);

`ifdef TLC_MON_STRICT_START_EN
  // cnt is zero in TRACK only before the first sample after reset
  assign start_pending = (cnt_q == '0);
`else
  assign start_pending = 1'b0;
`endif

  always_comb begin
    state_nx      = state_q;
    phase_nx      = phase_q;
    cnt_nx        = cnt_q;
    held_vld_nx   = held_vld_q;
    held_phase_nx = held_phase_q;
    cycles_nx     = cycles_q;
    f_seq         = 1'b0;
    f_timing      = 1'b0;

    case (state_q)
      ST_SYNC: begin
        if (samp_legal) begin
          held_vld_nx   = 1'b1;
          held_phase_nx = samp_phase;
          if (held_vld_q && held_phase_q != samp_phase) begin
            state_nx = ST_TRACK;
            phase_nx = samp_phase;
            cnt_nx   = CNT_ONE;
          end
        end else begin
          held_vld_nx = 1'b0;
        end
      end
      default: begin
        if (samp_legal) begin
          if (samp_phase == phase_q) begin
            if (cnt_q < t_cur)
              cnt_nx = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
            else
              f_timing = 1'b1;
          end else if (start_pending) begin
            f_seq = 1'b1;
          end else if (samp_phase == 2'(phase_q + 2'd1)) begin
            if (cnt_q != t_cur) begin
              f_timing = 1'b1;
            end else begin
              phase_nx = samp_phase;
              cnt_nx   = CNT_ONE;
              if (phase_q == PH_BY)
                cycles_nx = cycles_q + 8'd1;
            end
          end else begin
            f_seq    = 1'b1;
            f_timing = (cnt_q != t_cur);
          end
        end
      end
    endcase

    any_fault = samp_illegal | samp_conflict | f_seq | f_timing;

    if (state_q == ST_TRACK && any_fault) begin
      state_nx      = ST_SYNC;
      cnt_nx        = '0;
      held_vld_nx   = samp_legal;
      held_phase_nx = samp_phase;
    end

    countdown_nx = (state_nx == ST_TRACK) ? (t_of(phase_nx) - cnt_nx + CNT_ONE) : '0;
    // A fault on the clearing edge still lands in the flags
    flags_nx = (clr_fault ? 4'b0000 : flags_q) |
               {samp_illegal, samp_conflict, f_seq, f_timing};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
`ifdef TLC_MON_STRICT_START_EN
      state_q <= ST_TRACK;
`else
      state_q <= ST_SYNC;
`endif
      phase_q      <= PH_AG;
      cnt_q        <= '0;
      held_vld_q   <= 1'b0;
      held_phase_q <= PH_AG;
      cycles_q     <= 8'd0;
      countdown_q  <= '0;
      pulse_q      <= 1'b0;
      flags_q      <= 4'b0000;
    end else begin
      state_q      <= state_nx;
      phase_q      <= phase_nx;
      cnt_q        <= cnt_nx;
      held_vld_q   <= held_vld_nx;
      held_phase_q <= held_phase_nx;
      cycles_q     <= cycles_nx;
      countdown_q  <= countdown_nx;
      pulse_q      <= any_fault;
      flags_q      <= flags_nx;
    end
  end

  assign locked      = (state_q == ST_TRACK);
  assign phase       = phase_q;
  assign countdown   = countdown_q;
  assign cycles      = cycles_q;
  assign fault_pulse = pulse_q;
  assign fault_flags = flags_q;

endmodule

// File: tb/tb_tlc_lamp_monitor.sv
// Directed bench for tlc_lamp_monitor; expected values are hand-derived from the lamp sequences below.
module tb_tlc_lamp_monitor;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;
  localparam logic [1:0] X = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] lamp_a, lamp_b;
  logic       clr_fault;
  logic       locked;
  logic [1:0] phase;
  logic [3:0] countdown;
  logic [7:0] cycles;
  logic       fault_pulse;
  logic [3:0] fault_flags;

  int total  = 0;
  int passed = 0;

  tlc_lamp_monitor #(
    .T_AG(5), .T_AY(2), .T_BG(5), .T_BY(2), .CNT_W(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .lamp_a     (lamp_a),
    .lamp_b     (lamp_b),
    .clr_fault  (clr_fault),
    .locked     (locked),
    .phase      (phase),
    .countdown  (countdown),
    .cycles     (cycles),
    .fault_pulse(fault_pulse),
    .fault_flags(fault_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one sample; returns 1ns after the edge that captured it
  task automatic step(input logic [1:0] a, input logic [1:0] b, input logic clr);
    lamp_a    = a;
    lamp_b    = b;
    clr_fault = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input logic [1:0] a, input logic [1:0] b, input int n);
    for (int i = 0; i < n; i++) step(a, b, 1'b0);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    lamp_a    = R;
    lamp_b    = R;
    clr_fault = 1'b0;
    #12;
`ifdef TLC_MON_STRICT_START_EN
    chk("strict_rst_locked", locked, 1);
    chk("strict_rst_phase", phase, 0);
    chk("strict_rst_cd", countdown, 0);
    chk("strict_rst_flags", fault_flags, 0);
    rst = 1'b0;
    step(R, G, 1'b0);
    chk("strict_bg_flags", fault_flags, 4'b0010);
    chk("strict_bg_locked", locked, 0);
    chk("strict_bg_pulse", fault_pulse, 1);
    pulse_reset();
    chk("strict_rerst_flags", fault_flags, 0);
    step(G, R, 1'b0);
    chk("strict_ag_locked", locked, 1);
    chk("strict_ag_phase", phase, 0);
    chk("strict_ag_cd", countdown, 5);
    step(G, R, 1'b0);
    chk("strict_ag2_cd", countdown, 4);
    chk("strict_ag2_flags", fault_flags, 0);
`else
    chk("rst_locked", locked, 0);
    chk("rst_phase", phase, 0);
    chk("rst_cd", countdown, 0);
    chk("rst_cycles", cycles, 0);
    chk("rst_pulse", fault_pulse, 0);
    chk("rst_flags", fault_flags, 0);
    rst = 1'b0;

    // Normal sequence: lock on the first phase change
    run(G, R, 5);
    chk("t1_ag_unlocked", locked, 0);
    step(Y, R, 1'b0);
    chk("t1_ay_locked", locked, 1);
    chk("t1_ay_phase", phase, 1);
    chk("t1_ay_cd1", countdown, 2);
    step(Y, R, 1'b0);
    chk("t1_ay_cd2", countdown, 1);
    for (int i = 0; i < 5; i++) begin
      step(R, G, 1'b0);
      chk("t1_bg_cd", countdown, 32'(5 - i));
    end
    chk("t1_bg_phase", phase, 2);
    step(R, Y, 1'b0);
    chk("t1_by_cd1", countdown, 2);
    step(R, Y, 1'b0);
    chk("t1_by_cd2", countdown, 1);
    chk("t1_by_cycles", cycles, 0);
    step(G, R, 1'b0);
    chk("t1_ag_cycles", cycles, 1);
    chk("t1_ag_phase", phase, 0);
    chk("t1_ag_cd", countdown, 5);
    run(G, R, 4);
    chk("t1_ag_cd_end", countdown, 1);
    chk("t1_flags", fault_flags, 0);
    chk("t1_pulse", fault_pulse, 0);

    // AG held one cycle too long
    step(G, R, 1'b0);
    chk("t2_flags", fault_flags, 4'b0001);
    chk("t2_pulse", fault_pulse, 1);
    chk("t2_locked", locked, 0);
    chk("t2_cd", countdown, 0);
    step(Y, R, 1'b0);
    chk("t2_pulse_drop", fault_pulse, 0);
    step(Y, R, 1'b0);
    step(R, G, 1'b0);
    chk("t2_relock", locked, 1);
    chk("t2_relock_phase", phase, 2);
    chk("t2_relock_cd", countdown, 5);
    chk("t2_flags_sticky", fault_flags, 4'b0001);

    // AY cut short
    step(R, G, 1'b1);
    chk("t3_clr_flags", fault_flags, 0);
    chk("t3_clr_locked", locked, 1);
    chk("t3_clr_cd", countdown, 4);
    run(R, G, 3);
    run(R, Y, 2);
    run(G, R, 5);
    chk("t3_cycles", cycles, 2);
    step(Y, R, 1'b0);
    step(R, G, 1'b0);
    chk("t3_flags", fault_flags, 4'b0001);
    chk("t3_locked", locked, 0);
    chk("t3_pulse", fault_pulse, 1);

    // Conflict from a locked state, then an illegal code
    step(R, G, 1'b1);
    chk("t4_clr_flags", fault_flags, 0);
    step(R, Y, 1'b0);
    chk("t4_lock_by", locked, 1);
    chk("t4_lock_phase", phase, 3);
    step(R, Y, 1'b0);
    step(G, G, 1'b0);
    chk("t4_conflict_flags", fault_flags, 4'b0100);
    chk("t4_conflict_locked", locked, 0);
    chk("t4_conflict_pulse", fault_pulse, 1);
    step(G, R, 1'b1);
    chk("t4_clr2_flags", fault_flags, 0);
    step(Y, R, 1'b0);
    chk("t4_lock_ay", locked, 1);
    step(X, R, 1'b0);
    chk("t4_illegal_flags", fault_flags, 4'b1000);
    chk("t4_illegal_locked", locked, 0);

    // Out-of-order phase, then clear colliding with a new fault
    step(R, Y, 1'b1);
    chk("t5_clr_flags", fault_flags, 0);
    step(G, R, 1'b0);
    chk("t5_lock_ag", locked, 1);
    chk("t5_ag_cd", countdown, 5);
    run(G, R, 4);
    chk("t5_ag_cd_end", countdown, 1);
    step(R, G, 1'b0);
    chk("t5_seq_flags", fault_flags, 4'b0010);
    chk("t5_seq_locked", locked, 0);
    chk("t5_seq_pulse", fault_pulse, 1);
    step(Y, G, 1'b1);
    chk("t5_clr_vs_fault", fault_flags, 4'b0100);
    chk("t5_clr_vs_pulse", fault_pulse, 1);
    chk("t5_cycles_kept", cycles, 2);

    // Asynchronous reset between edges drops everything
    pulse_reset();
    chk("rst_mid_cycles", cycles, 0);
    chk("rst_mid_flags", fault_flags, 0);
    chk("rst_mid_locked", locked, 0);
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
